dfd_apb_req_master: RTL and testbench
=====================================

// Module: dfd_apb_req_master
// PURPOSE
//  Request-to-APB4 master driving the dfd_mmrs APB slave port (paddr/psel/penable/pwrite/pstrb/pwdata in; prdata/pready/pslverr back).
//  Takes one register request at a time over valid/ready. Runs a single APB transfer. Returns read data and error over valid/ready.
//  Sits between the debug-transport decoder and dfd_mmrs. Lets firmware and debug-module accesses reach the DFD CSRs without a bus fabric.
// PARAMETERS
//  ADDR_W          DFD_APB_ADDR_WIDTH   paddr/req_addr width
//  DATA_W          DFD_APB_DATA_WIDTH   pwdata/prdata width
//  STRB_W          DFD_APB_PSTRB_WIDTH  pstrb width (DATA_W/8)
//  TIMEOUT_CYCLES  256                  ACCESS-phase cycles before abort (only with DFD_APB_MST_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock
//  reset_n        in   1       synchronous, active-low reset
//  req_valid      in   1       request present
//  req_ready      out  1       request accepted when valid&ready
//  req_write      in   1       1=write, 0=read
//  req_addr       in   ADDR_W  byte address
//  req_wdata      in   DATA_W  write data
//  req_strb       in   STRB_W  write byte strobes
//  rsp_valid      out  1       response present
//  rsp_ready      in   1       response consumed when valid&ready
//  rsp_rdata      out  DATA_W  read data (0 for writes and errors)
//  rsp_err        out  1       pslverr or timeout
//  rsp_timeout    out  1       abort caused by timeout
//  paddr/pwrite/pstrb/pwdata  out  ADDR_W/1/STRB_W/DATA_W  APB master drive
//  psel/penable   out  1       APB phase control
//  prdata         in   DATA_W  APB read data
//  pready/pslverr in   1       APB completion/error
//  err_count      out  16      saturating count of rsp_err responses
// BEHAVIOUR
//  - All outputs are registered. On reset every output is 0 and the FSM is IDLE.
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid, capture addr/write/wdata/strb and go to SETUP. Reads force pstrb=0 and pwdata=0.
//  - SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pstrb/pwdata valid. Go to ACCESS.
//  - ACCESS: psel=1, penable=1, APB signals held stable.
//    - When pready=1 is sampled: capture rsp_rdata = pwrite ? 0 : (pslverr ? 0 : prdata) and rsp_err = pslverr. Then psel=penable=0 and go to RESP.
//    - pslverr is ignored unless pready=1.
//  - RESP: rsp_valid=1 and fields stable until rsp_ready. On handshake go to IDLE; req_ready rises the following cycle.
//  - req_ready=0 in SETUP/ACCESS/RESP. req_valid there is not consumed.
//  - Latency: request accepted at edge T -> psel at T+1 -> penable at T+2.
//  - Response timing: pready sampled at edge P -> rsp_valid from P+1.
//  - Minimum request-to-request spacing is 4 cycles with zero-wait slave and rsp_ready=1.
//  - err_count increments on each rsp_valid&rsp_ready with rsp_err=1 and saturates at 16'hFFFF.
//  - Reset asserted mid-transfer: the next edge returns to IDLE with psel=penable=0. No response is produced and err_count clears.
// CONFIGURATION
//  DFD_APB_MST_TIMEOUT_EN defined:
//    - A counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
//    - Abort when the counter reaches TIMEOUT_CYCLES-1 with pready still 0. The next edge drops psel/penable and enters RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//    - If pready=1 arrives in the same cycle as the limit, it wins and it is a normal completion.
//  Undefined: ACCESS waits indefinitely. rsp_timeout is tied 0. No counter logic exists.
// STRUCTURE
//  - dfd_pkg: add typedef enum logic [1:0] {APBM_IDLE, APBM_SETUP, APBM_ACCESS, APBM_RESP} DfdApbMstState_e.
//  - dfd_pkg: add packed structs DfdApbMstReq_s and DfdApbMstRsp_s.
//  - dfd_pkg: add localparam DFD_APB_MST_ERRCNT_W = 16.
//  - Sub-module dfd_apb_timeout_ctr (clear/inc/expired, width $clog2(TIMEOUT_CYCLES)), instantiated only under DFD_APB_MST_TIMEOUT_EN.
//  - FSM, capture registers and err_count live in the top.
// TESTING
//  - Bench: this block connected to dfd_mmrs (INTERNAL_MMRS=1, BASE_ADDR=0). APB protocol checker on psel/penable stability.
//  - Write then read: write 0x0 data 0xCEED1020 strb 0xF, read 0x0 -> rsp_rdata=0xCEED1020, rsp_err=0.
//    Cycle check: psel at T+1, penable at T+2, rsp_valid 1 cycle after pready.
//  - Partial strobe: write 0xFFFFFFFF strb 0x3 over 0x0, read back -> 0x0000FFFF (writable bits).
//    Read pstrb observed = 0.
//  - Slave error: read an unmapped address -> pslverr=1 -> rsp_err=1, rsp_rdata=0, err_count=1.
//  - Backpressure: hold rsp_ready=0 for 10 cycles with req_valid=1 -> rsp fields stable, req_ready=0, no second psel.
//    Release -> exactly one new transfer.
//  - Timeout (macro on, TIMEOUT_CYCLES=8, stub slave pready=0): rsp_timeout=1, rsp_err=1 after 8 ACCESS cycles.
//    Reset asserted during ACCESS: psel=0 next edge, no rsp_valid, err_count=0.

Source files
------------

// File: rtl/dfd_pkg.sv
// Shared types and widths for the DFD APB request master.
package dfd_pkg;

   localparam int DFD_APB_ADDR_WIDTH   = 12;
   localparam int DFD_APB_DATA_WIDTH   = 32;
   localparam int DFD_APB_PSTRB_WIDTH  = DFD_APB_DATA_WIDTH / 8;
   localparam int DFD_APB_MST_ERRCNT_W = 16;

   typedef enum logic [1:0] {
      APBM_IDLE,
      APBM_SETUP,
      APBM_ACCESS,
      APBM_RESP
   } DfdApbMstState_e;

   typedef struct packed {
      logic                           write;
      logic [DFD_APB_ADDR_WIDTH-1:0]  addr;
      logic [DFD_APB_DATA_WIDTH-1:0]  wdata;
      logic [DFD_APB_PSTRB_WIDTH-1:0] strb;
   } DfdApbMstReq_s;

   typedef struct packed {
      logic [DFD_APB_DATA_WIDTH-1:0] rdata;
      logic                          err;
      logic                          timeout;
   } DfdApbMstRsp_s;

endpackage

// File: rtl/dfd_apb_timeout_ctr.sv
// ACCESS-phase wait counter used to abort a stalled APB transfer.
// Present only when DFD_APB_MST_TIMEOUT_EN is defined.
`ifdef DFD_APB_MST_TIMEOUT_EN
module dfd_apb_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/dfd_apb_req_master.sv
// Single-outstanding request/response to APB4 master for the DFD CSR slave.
// Optional ACCESS-phase abort enabled by DFD_APB_MST_TIMEOUT_EN.
module dfd_apb_req_master
   import dfd_pkg::*;
#(
   parameter int ADDR_W = DFD_APB_ADDR_WIDTH,
   parameter int DATA_W = DFD_APB_DATA_WIDTH,
   parameter int STRB_W = DFD_APB_PSTRB_WIDTH
`ifdef DFD_APB_MST_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_write,
   input  logic [ADDR_W-1:0]              req_addr,
   input  logic [DATA_W-1:0]              req_wdata,
   input  logic [STRB_W-1:0]              req_strb,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [DATA_W-1:0]              rsp_rdata,
   output logic                           rsp_err,
   output logic                           rsp_timeout,
   output logic [ADDR_W-1:0]              paddr,
   output logic                           pwrite,
   output logic [STRB_W-1:0]              pstrb,
   output logic [DATA_W-1:0]              pwdata,
   output logic                           psel,
   output logic                           penable,
   input  logic [DATA_W-1:0]              prdata,
   input  logic                           pready,
   input  logic                           pslverr,
   output logic [DFD_APB_MST_ERRCNT_W-1:0] err_count
);

   DfdApbMstState_e                state_q, state_d;
   logic [ADDR_W-1:0]              paddr_q, paddr_d;
   logic                           pwrite_q, pwrite_d;
   logic [STRB_W-1:0]              pstrb_q, pstrb_d;
   logic [DATA_W-1:0]              pwdata_q, pwdata_d;
   logic                           psel_q, psel_d;
   logic                           penable_q, penable_d;
   logic                           req_ready_q, req_ready_d;
   logic                           rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]              rsp_rdata_q, rsp_rdata_d;
   logic                           rsp_err_q, rsp_err_d;
   logic [DFD_APB_MST_ERRCNT_W-1:0] err_count_q, err_count_d;

`ifdef DFD_APB_MST_TIMEOUT_EN
   logic rsp_timeout_q, rsp_timeout_d;
   logic tmo_clear, tmo_inc, tmo_expired;

   dfd_apb_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (tmo_clear),
      .inc    (tmo_inc),
      .expired(tmo_expired)
   );
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pstrb_d     = pstrb_q;
      pwdata_d    = pwdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      err_count_d = err_count_q;
`ifdef DFD_APB_MST_TIMEOUT_EN
      rsp_timeout_d = rsp_timeout_q;
      tmo_clear     = 1'b0;
      tmo_inc       = 1'b0;
`endif
      case (state_q)
         APBM_IDLE: begin
            if (req_valid && req_ready_q) begin
               state_d  = APBM_SETUP;
               paddr_d  = req_addr;
               pwrite_d = req_write;
               pstrb_d  = req_write ? req_strb  : '0;
               pwdata_d = req_write ? req_wdata : '0;
            end
         end
         APBM_SETUP: begin
            state_d = APBM_ACCESS;
`ifdef DFD_APB_MST_TIMEOUT_EN
            tmo_clear = 1'b1;
`endif
         end
         APBM_ACCESS: begin
            // pready has priority over an expiring timeout in the same cycle.
            if (pready) begin
               state_d     = APBM_RESP;
               rsp_rdata_d = (pwrite_q || pslverr) ? '0 : prdata;
               rsp_err_d   = pslverr;
`ifdef DFD_APB_MST_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
            end else if (tmo_expired) begin
               state_d       = APBM_RESP;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               tmo_inc = 1'b1;
`endif
            end
         end
         APBM_RESP: begin
            if (rsp_ready) begin
               state_d     = APBM_IDLE;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
`ifdef DFD_APB_MST_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
               if (rsp_err_q && (err_count_q != '1)) begin
                  err_count_d = err_count_q + DFD_APB_MST_ERRCNT_W'(1);
               end
            end
         end
         default: state_d = APBM_IDLE;
      endcase

      // Phase outputs are decoded from the next state so they are registered yet cycle-exact.
      req_ready_d = (state_d == APBM_IDLE);
      psel_d      = (state_d == APBM_SETUP) || (state_d == APBM_ACCESS);
      penable_d   = (state_d == APBM_ACCESS);
      rsp_valid_d = (state_d == APBM_RESP);
   end

   // NOTE: state uses non-blocking assignments; data registers are reset too because every output must read 0 in reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= APBM_IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pstrb_q     <= '0;
         pwdata_q    <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pstrb_q     <= pstrb_d;
         pwdata_q    <= pwdata_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         err_count_q <= err_count_d;
      end
   end

`ifdef DFD_APB_MST_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_timeout_q <= 1'b0;
      end else begin
         rsp_timeout_q <= rsp_timeout_d;
      end
   end
   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign pstrb     = pstrb_q;
   assign pwdata    = pwdata_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_dfd_apb_req_master.sv
// Self-checking bench for dfd_apb_req_master against a small APB register-file slave model.
// Timeout sequence is exercised when DFD_APB_MST_TIMEOUT_EN is defined.
module tb_dfd_apb_req_master;
   import dfd_pkg::*;

   localparam int AW = DFD_APB_ADDR_WIDTH;
   localparam int DW = DFD_APB_DATA_WIDTH;
   localparam int SW = DFD_APB_PSTRB_WIDTH;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [SW-1:0] req_strb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic [AW-1:0] paddr;
   logic          pwrite;
   logic [SW-1:0] pstrb;
   logic [DW-1:0] pwdata;
   logic          psel;
   logic          penable;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;
   logic [15:0]   err_count;

   always #5 clk = ~clk;

   dfd_apb_req_master #(
      .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)
`ifdef DFD_APB_MST_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
      .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .err_count(err_count)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave model: 16 fully writable words at 0x00-0x3C, anything else answers pslverr.
   logic [DW-1:0] mem [16];
   int  wait_states = 0;
   bit  stuck = 1'b0;
   int  wait_cnt = 0;
   int  cyc = 0;
   int  pready_cyc = 0;
   int  setup_count = 0;
   wire access = psel && penable;
   wire mapped = (paddr < AW'(12'h040));

   assign pready  = access && !stuck && (wait_cnt >= wait_states);
   assign pslverr = pready && !mapped;
   assign prdata  = mapped ? mem[paddr[5:2]] : 32'hDEAD_BEEF;

   initial for (int i = 0; i < 16; i++) mem[i] = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pready) pready_cyc <= cyc + 1;
      if (psel && !penable) setup_count <= setup_count + 1;
      if (access && !pready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (pready && pwrite && mapped) begin
         for (int b = 0; b < SW; b++) begin
            if (pstrb[b]) mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
         end
      end
   end

   // APB protocol monitor: signals held through SETUP/ACCESS, ENABLE only after SETUP.
   logic          prev_rstn = 1'b0;
   logic          prev_psel = 1'b0;
   logic          prev_done = 1'b0;
   logic [48:0]   prev_bus = '0;

   always @(posedge clk) begin
      if (reset_n && prev_rstn && !rsp_timeout) begin
         if (prev_psel && !prev_done)
            check("apb_stable", {psel, penable, pwrite, pstrb, paddr, pwdata}, {2'b11, prev_bus});
         if (penable)
            check("apb_setup_first", 64'(prev_psel), 64'd1);
      end
      prev_rstn <= reset_n;
      prev_psel <= psel;
      prev_done <= psel && penable && pready;
      prev_bus  <= {pwrite, pstrb, paddr, pwdata};
   end

   typedef struct {
      DfdApbMstReq_s req;
      int            ws;
      logic [31:0]   exp_rdata;
      logic          exp_err;
      logic [15:0]   exp_errcnt;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic [11:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int ws, input logic [31:0] rd,
                               input logic e, input logic [15:0] ec);
      vec_t v;
      v.req.write = w;
      v.req.addr  = a;
      v.req.wdata = d;
      v.req.strb  = s;
      v.ws        = ws;
      v.exp_rdata = rd;
      v.exp_err   = e;
      v.exp_errcnt = ec;
      return v;
   endfunction

   // Drives a request and returns #1 after the accepting edge with req_valid dropped.
   task automatic start_req(input DfdApbMstReq_s r, input string tag, output int t_acc);
      int n = 0;
      req_write = r.write;
      req_addr  = r.addr;
      req_wdata = r.wdata;
      req_strb  = r.strb;
      req_valid = 1'b1;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_accept"}, 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      t_acc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (!rsp_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int t_acc;
      wait_states = v.ws;
      start_req(v.req, tag, t_acc);
      check({tag, "_setup"}, {psel, penable, pstrb, paddr, pwdata},
            {2'b10, (v.req.write ? v.req.strb : 4'h0), v.req.addr,
             (v.req.write ? v.req.wdata : 32'h0)});
      @(posedge clk); #1;
      check({tag, "_access"}, {psel, penable}, 2'b11);
      wait_rsp(tag);
      check({tag, "_rsp_lat"}, 64'(cyc), 64'(pready_cyc));
      if (v.ws == 0) check({tag, "_rsp_t2"}, 64'(cyc), 64'(t_acc + 2));
      check({tag, "_rsp"}, {psel, penable, rsp_timeout, rsp_err, rsp_rdata},
            {3'b000, v.exp_err, v.exp_rdata});
      @(posedge clk); #1;
      check({tag, "_post"}, {rsp_valid, req_ready, err_count}, {2'b01, v.exp_errcnt});
   endtask

   vec_t vecs [10];
   DfdApbMstReq_s r;
   int t0, base;

   initial begin
      vecs[0] = mk(1, 12'h000, 32'hCEED_1020, 4'hF, 0, 32'h0,         0, 16'd0);
      vecs[1] = mk(0, 12'h000, 32'h1111_1111, 4'hF, 0, 32'hCEED_1020, 0, 16'd0);
      vecs[2] = mk(1, 12'h004, 32'h0000_0000, 4'hF, 0, 32'h0,         0, 16'd0);
      vecs[3] = mk(1, 12'h004, 32'hFFFF_FFFF, 4'h3, 0, 32'h0,         0, 16'd0);
      vecs[4] = mk(0, 12'h004, 32'h0,         4'hF, 0, 32'h0000_FFFF, 0, 16'd0);
      vecs[5] = mk(0, 12'h080, 32'h0,         4'h0, 0, 32'h0,         1, 16'd1);
      vecs[6] = mk(1, 12'h084, 32'h5555_5555, 4'hF, 0, 32'h0,         1, 16'd2);
      vecs[7] = mk(0, 12'h000, 32'h0,         4'h0, 3, 32'hCEED_1020, 0, 16'd2);
      vecs[8] = mk(1, 12'h008, 32'hA5A5_A5A5, 4'hC, 1, 32'h0,         0, 16'd2);
      vecs[9] = mk(0, 12'h008, 32'h0,         4'h0, 2, 32'hA5A5_0000, 0, 16'd2);

      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {req_ready, rsp_valid, psel, penable, pwrite, rsp_err, rsp_timeout}, 7'b0);
      check("rst_apb", {paddr, pstrb, pwdata}, 48'h0);
      check("rst_rsp", {rsp_rdata, err_count}, 48'h0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Backpressure: response held 10 cycles while a second request waits.
      rsp_ready = 1'b0;
      wait_states = 0;
      r = '{write: 1'b0, addr: 12'h000, wdata: 32'h0, strb: 4'h0};
      start_req(r, "bp0", t0);
      base = setup_count;
      req_write = 1'b1;
      req_addr  = 12'h00C;
      req_wdata = 32'h1234_5678;
      req_strb  = 4'hF;
      req_valid = 1'b1;
      wait_rsp("bp0");
      check("bp0_one_setup", 64'(setup_count), 64'(base + 1));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d", i), {rsp_valid, req_ready, psel, rsp_err, rsp_rdata},
               {4'b1000, 32'hCEED_1020});
      end
      check("bp_no_setup", 64'(setup_count), 64'(base + 1));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {rsp_valid, req_ready}, 2'b01);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp1_setup", {psel, penable, paddr}, {2'b10, 12'h00C});
      wait_rsp("bp1");
      check("bp1_rsp", {rsp_err, rsp_rdata}, 33'h0);
      repeat (6) @(posedge clk);
      #1;
      check("bp_exactly_one", 64'(setup_count), 64'(base + 2));
      run_vec(mk(0, 12'h00C, 32'h0, 4'h0, 0, 32'h1234_5678, 0, 16'd2), "bp_rd");

      stuck = 1'b1;
      r = '{write: 1'b0, addr: 12'h000, wdata: 32'h0, strb: 4'h0};
`ifdef DFD_APB_MST_TIMEOUT_EN
      begin
         int acc = 0;
         int n = 0;
         start_req(r, "tmo", t0);
         while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            if (psel && penable) acc++;
            n++;
         end
         check("tmo_rsp_seen", 64'(rsp_valid), 64'd1);
         check("tmo_access_cycles", 64'(acc), 64'd8);
         check("tmo_rsp", {psel, penable, rsp_timeout, rsp_err, rsp_rdata}, {4'b0011, 32'h0});
         @(posedge clk); #1;
         check("tmo_errcnt", 64'(err_count), 64'd3);
      end
      start_req(r, "rst_mid", t0);
      repeat (3) @(posedge clk);
      #1;
`else
      start_req(r, "rst_mid", t0);
      repeat (300) @(posedge clk);
      #1;
      check("no_tmo_wait", {psel, penable, rsp_valid, rsp_timeout}, 4'b1100);
`endif
      check("rst_mid_in_access", {psel, penable}, 2'b11);
      @(negedge clk) reset_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_apb", {psel, penable, rsp_valid}, 3'b000);
      check("rst_mid_errcnt", 64'(err_count), 64'd0);
      @(negedge clk) begin
         reset_n = 1'b1;
         stuck = 1'b0;
      end
      repeat (4) begin
         @(posedge clk); #1;
         check("rst_mid_quiet", {rsp_valid, psel}, 2'b00);
      end
      run_vec(mk(0, 12'h000, 32'h0, 4'h0, 0, 32'hCEED_1020, 0, 16'd0), "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
